audio_mixer: RTL and testbench

Parametrised multi-channel audio sample mixer and the successor to the plain two-input combinational adder. It accepts one frame of CHANNELS signed samples per transaction and sums the channels selected by a per-frame enable mask, one channel per clock, through a single shared adder. It applies an optional arithmetic attenuation shift and returns a WIDTH-bit result over a valid/ready handshake. It sits between the per-source sample paths and the output DAC/serialiser path.

---
 rtl/audio_mixer.sv | 116 +++++++++++
 tb/tb_audio_mixer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mixer.sv
// audio_mixer: sums the masked channels of one frame, one channel per clock, through a
// single shared adder. Define MIXER_SATURATE_EN to clamp the result instead of wrapping it.
module audio_mixer #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SHIFT    = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_mask,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_clip
);
    localparam int ACCW = WIDTH + $clog2(CHANNELS);
    localparam int IDXW = $clog2(CHANNELS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CHANNELS - 1);

    if (WIDTH < 2)                   $error("audio_mixer: WIDTH must be 2 or greater");
    if (CHANNELS < 2)                $error("audio_mixer: CHANNELS must be 2 or greater");
    if (SHIFT < 0 || SHIFT >= WIDTH) $error("audio_mixer: SHIFT must be in [0, WIDTH)");

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                  state;
    logic [IDXW-1:0]         idx;
    logic signed [ACCW-1:0]  acc;
    logic [WIDTH-1:0]        samples_q [CHANNELS];
    logic [CHANNELS-1:0]     mask_q;

    logic signed [ACCW-1:0]  term;
    logic signed [ACCW-1:0]  sum;
    logic [WIDTH-1:0]        fmt_data;
    logic                    fmt_clip;

    function automatic logic signed [ACCW-1:0] sext(input logic [WIDTH-1:0] s);
        return {{(ACCW-WIDTH){s[WIDTH-1]}}, s};
    endfunction

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Both ready and valid come from registered state only, never from the partner's signal.
    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);

`ifdef MIXER_SATURATE_EN
    localparam logic [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};
    logic signed [ACCW-1:0] shifted;
`endif

    always_comb begin
        term = mask_q[idx] ? sext(samples_q[idx]) : '0;
        sum  = acc + term;
`ifdef MIXER_SATURATE_EN
        shifted = sum >>> SHIFT;
        if (shifted > sext(MAX_W)) begin
            fmt_data = MAX_W;
            fmt_clip = 1'b1;
        end else if (shifted < sext(MIN_W)) begin
            fmt_data = MIN_W;
            fmt_clip = 1'b1;
        end else begin
            fmt_data = shifted[WIDTH-1:0];
            fmt_clip = 1'b0;
        end
`else
        fmt_data = WIDTH'(sum >>> SHIFT);
        fmt_clip = 1'b0;
`endif
    end

    // The captured frame is held in samples_q/mask_q so input changes after acceptance are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            acc      <= '0;
            out_data <= '0;
            out_clip <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            samples_q[i] <= in_data[i*WIDTH +: WIDTH];
                        end
                        mask_q <= in_mask;
                        acc    <= '0;
                        idx    <= '0;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= sum;
                    if (idx == LAST_IDX) begin
                        out_data <= fmt_data;
                        out_clip <= fmt_clip;
                        state    <= DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_mixer.sv
// Bench for audio_mixer: two instances (SHIFT=0 and SHIFT=2) share one stimulus stream and
// are checked every cycle against a frame-level arithmetic model.
`timescale 1ns/1ps
module tb_audio_mixer;
    localparam int WIDTH    = 16;
    localparam int CHANNELS = 4;
    localparam int DW       = CHANNELS * WIDTH;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             in_valid  = 1'b0;
    logic [DW-1:0]    in_data   = '0;
    logic [CHANNELS-1:0] in_mask = '0;
    logic             out_ready = 1'b0;
    logic             in_ready, out_valid, out_clip;
    logic [WIDTH-1:0] out_data;
    logic             in_ready_s, out_valid_s, out_clip_s;
    logic [WIDTH-1:0] out_data_s;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] exp_s_q[$];
    bit pending    = 1'b0;
    int cyc        = 0;
    int acc_cyc    = 0;
    bit check_en   = 1'b0;
    bit rand_ready = 1'b0;

    audio_mixer #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SHIFT(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mask(in_mask), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_clip(out_clip)
    );

    audio_mixer #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SHIFT(2)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_mask(in_mask), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .out_clip(out_clip_s)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Frame-level reference: plain integer sum of masked channels, shift, then format.
    function automatic logic [WIDTH:0] mix_model(input logic [DW-1:0] d,
                                                 input logic [CHANNELS-1:0] m, input int sh);
        int sum = 0;
        int s;
        int hi = (1 << (WIDTH-1)) - 1;
        int lo = -(1 << (WIDTH-1));
        logic signed [WIDTH-1:0] smp;
        for (int i = 0; i < CHANNELS; i++) begin
            smp = d[i*WIDTH +: WIDTH];
            if (m[i]) sum += smp;
        end
        s = sum >>> sh;
`ifdef MIXER_SATURATE_EN
        if (s > hi) return {1'b1, hi[WIDTH-1:0]};
        if (s < lo) return {1'b1, lo[WIDTH-1:0]};
`endif
        return {1'b0, s[WIDTH-1:0]};
    endfunction

    function automatic logic [DW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {WIDTH'(d), WIDTH'(c), WIDTH'(b), WIDTH'(a)};
    endfunction

    function automatic logic [WIDTH-1:0] rand_sample();
        case ($urandom_range(0, 3))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: tracks whether a frame is outstanding and when its result becomes visible.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                pending = 1'b0;
                exp_q.delete();
                exp_s_q.delete();
            end else if (pending) begin
                if ((cyc - 1 - acc_cyc >= CHANNELS) && out_ready) begin
                    pending = 1'b0;
                    void'(exp_q.pop_front());
                    void'(exp_s_q.pop_front());
                end
            end else if (in_valid) begin
                exp_q.push_back(mix_model(in_data, in_mask, 0));
                exp_s_q.push_back(mix_model(in_data, in_mask, 2));
                acc_cyc = cyc;
                pending = 1'b1;
            end
        end
    end

    // Scoreboard compare on every falling edge.
    initial begin
        bit er, ev;
        logic [WIDTH:0] e, es;
        forever begin
            @(negedge clk);
            if (check_en) begin
                er = !pending && !reset;
                ev = pending && (cyc - acc_cyc >= CHANNELS);
                check("in_ready", in_ready, er);
                check("in_ready_s", in_ready_s, er);
                check("out_valid", out_valid, ev);
                check("out_valid_s", out_valid_s, ev);
                if (ev && exp_q.size() > 0) begin
                    e  = exp_q[0];
                    es = exp_s_q[0];
                    check("out_data", out_data, e[WIDTH-1:0]);
                    check("out_clip", out_clip, e[WIDTH]);
                    check("out_data_s", out_data_s, es[WIDTH-1:0]);
                    check("out_clip_s", out_clip_s, es[WIDTH]);
                end
            end
        end
    end

    // Random backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // driver tasks: entered and left just after a rising edge
    task automatic send_frame(input logic [DW-1:0] d, input logic [CHANNELS-1:0] m);
        int n = 0;
        in_data  = d;
        in_mask  = m;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_mask  = CHANNELS'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL valid_timeout: out_valid still 0 after %0d cycles, required 1", lat);
        end
    endtask

    task automatic run_case(input string name, input logic [DW-1:0] d, input logic [CHANNELS-1:0] m,
                            input logic [WIDTH:0] exp0, input logic [WIDTH:0] exp2);
        int lat;
        send_frame(d, m);
        wait_valid(lat);
        check({name, "_latency"}, lat, CHANNELS + 1);
        check({name, "_shift0"}, {out_clip, out_data}, exp0);
        check({name, "_shift2"}, {out_clip_s, out_data_s}, exp2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int n;

        check("model_basic",   mix_model(pack4(100, 200, -50, 7), 4'hF, 0), 17'h0_0101);
        check("model_mask",    mix_model(pack4(1000, 2000, 3000, 4000), 4'b0101, 0), 17'h0_0FA0);
        check("model_zero",    mix_model(pack4(1000, 2000, 3000, 4000), 4'b0000, 0), 17'h0_0000);
        check("model_shift2",  mix_model(pack4(-32768, -32768, -32768, -32768), 4'hF, 2), 17'h0_8000);
`ifdef MIXER_SATURATE_EN
        check("model_overflow", mix_model(pack4(28672, 28672, 28672, 28672), 4'hF, 0), 17'h1_7FFF);
`else
        check("model_overflow", mix_model(pack4(28672, 28672, 28672, 28672), 4'hF, 0), 17'h0_C000);
`endif

        repeat (2) @(posedge clk);
        check_en = 1'b1;
        @(negedge clk);
        check("reset_out_data", out_data, 0);
        check("reset_out_clip", out_clip, 0);
        check("reset_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        run_case("basic", pack4(100, 200, -50, 7), 4'hF, 17'h0_0101, 17'h0_0040);
`ifdef MIXER_SATURATE_EN
        run_case("overflow", pack4(28672, 28672, 28672, 28672), 4'hF, 17'h1_7FFF, 17'h0_7000);
        run_case("shift", pack4(-32768, -32768, -32768, -32768), 4'hF, 17'h1_8000, 17'h0_8000);
`else
        run_case("overflow", pack4(28672, 28672, 28672, 28672), 4'hF, 17'h0_C000, 17'h0_7000);
        run_case("shift", pack4(-32768, -32768, -32768, -32768), 4'hF, 17'h0_0000, 17'h0_8000);
`endif
        run_case("mask0101", pack4(1000, 2000, 3000, 4000), 4'b0101, 17'h0_0FA0, 17'h0_03E8);
        run_case("mask0000", pack4(1000, 2000, 3000, 4000), 4'b0000, 17'h0_0000, 17'h0_0000);

        // backpressure: result must hold and new frames must be refused
        out_ready = 1'b0;
        send_frame(pack4(11, 22, 33, 44), 4'hF);
        wait_valid(lat);
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                in_valid = 1'b1;
                in_data  = pack4(9, 9, 9, 9);
                in_mask  = 4'hF;
            end
            if (i == 5) in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        check("bp_hold_data", out_data, 16'd110);
        check("bp_hold_ready", in_ready, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_release", in_ready, 1);
        @(posedge clk);
        #1;

        // reset in the middle of a frame
        send_frame(pack4(5, 6, 7, 8), 4'hF);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_reset_ready", in_ready, 1);
        @(posedge clk);
        #1;
        run_case("after_reset", pack4(1, 2, 3, 4), 4'hF, 17'h0_000A, 17'h0_0002);

        // randomized frames with random gaps and random backpressure
        rand_ready = 1'b1;
        for (int f = 0; f < 150; f++) begin
            logic [DW-1:0] d;
            for (int c = 0; c < CHANNELS; c++) d[c*WIDTH +: WIDTH] = rand_sample();
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send_frame(d, CHANNELS'($urandom));
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        n = 0;
        while (pending && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check("drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
